commit_trace_buffer: RTL and testbench

Synthesizable commit-trace capture stage for the single-cycle `cpu`. It sits directly downstream of the core's commit-point signals: register write, memory access and halt. Each cycle it classifies the committing instruction as NOP/branch, register write, load, store or halt. It stamps the record with a running instruction number and buffers it in a FIFO that a host or bench drains through a valid/ready handshake, replacing per-cycle `$fdisplay` tracing in long runs.

---
 rtl/commit_trace_buffer.sv | 159 +++++++++++++++
 tb/tb_commit_trace_buffer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_buffer.sv
// Commit-trace capture: classifies each committing instruction and queues a stamped record for a host to drain.
// Optional TRACE_CYCLE_STAMP_EN stores a saturating cycle stamp per record.
module commit_trace_buffer #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pc,
  input  logic        reg_write,
  input  logic [3:0]  write_reg,
  input  logic [15:0] write_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_data,
  input  logic        hlt,
  output logic        tr_valid,
  input  logic        tr_ready,
  output logic [2:0]  tr_kind,
  output logic [31:0] tr_inum,
  output logic [15:0] tr_pc,
  output logic [3:0]  tr_reg,
  output logic [15:0] tr_value,
  output logic [15:0] tr_addr,
  output logic [31:0] tr_cycle,
  output logic        overflow,
  output logic        halted,
  output logic        done
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [2:0] KIND_NOP   = 3'd0;
  localparam logic [2:0] KIND_REG   = 3'd1;
  localparam logic [2:0] KIND_LOAD  = 3'd2;
  localparam logic [2:0] KIND_STORE = 3'd3;
  localparam logic [2:0] KIND_HALT  = 3'd4;

  typedef struct packed {
    logic [2:0]  kind;
    logic [31:0] inum;
    logic [15:0] pc;
    logic [3:0]  regIdx;
    logic [15:0] value;
    logic [15:0] addr;
`ifdef TRACE_CYCLE_STAMP_EN
    logic [31:0] cycle;
`endif
  } rec_t;

`ifdef TRACE_CYCLE_STAMP_EN
  function automatic logic [31:0] satInc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] cycleCnt;
`endif

  rec_t          mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [CW-1:0] count;
  logic [31:0]   inum;

  rec_t rec_p0;
  logic vld_p0;
  logic full;
  logic empty;
  logic pushFire;
  logic popFire;
  logic dropFire;
  rec_t headRec;

  // Stage p0: classify the committing instruction
  always_comb begin
    rec_p0      = '0;
    rec_p0.inum = inum;
    rec_p0.pc   = pc;
`ifdef TRACE_CYCLE_STAMP_EN
    rec_p0.cycle = cycleCnt;
`endif
    if (reg_write) begin
      rec_p0.kind   = mem_read ? KIND_LOAD : KIND_REG;
      rec_p0.regIdx = write_reg;
      rec_p0.value  = write_data;
      rec_p0.addr   = mem_read ? mem_addr : 16'd0;
    end else if (hlt) begin
      rec_p0.kind = KIND_HALT;
    end else if (mem_write) begin
      rec_p0.kind  = KIND_STORE;
      rec_p0.value = mem_data;
      rec_p0.addr  = mem_addr;
    end else begin
      rec_p0.kind = KIND_NOP;
    end
  end

  assign vld_p0   = !halted;
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign popFire  = !empty && tr_ready;
  // A pop frees the slot in the same edge, so a full FIFO can still accept
  assign pushFire = vld_p0 && (!full || popFire);
  assign dropFire = vld_p0 && full && !popFire;

  // Stage p1: FIFO control state
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      inum     <= '0;
      overflow <= 1'b0;
      halted   <= 1'b0;
`ifdef TRACE_CYCLE_STAMP_EN
      cycleCnt <= '0;
`endif
    end else begin
      if (pushFire) wrPtr <= wrPtr + AW'(1);
      if (popFire)  rdPtr <= rdPtr + AW'(1);
      case ({pushFire, popFire})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (vld_p0) inum <= inum + 32'd1;
      if (dropFire) overflow <= 1'b1;
      if (vld_p0 && rec_p0.kind == KIND_HALT) halted <= 1'b1;
`ifdef TRACE_CYCLE_STAMP_EN
      cycleCnt <= satInc32(cycleCnt);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (pushFire) mem[wrPtr] <= rec_p0;
  end

  // Head presentation: zeroed whenever the FIFO is empty
  always_comb begin
    headRec = '0;
    if (!empty) headRec = mem[rdPtr];
  end

  assign tr_valid = !empty;
  assign tr_kind  = headRec.kind;
  assign tr_inum  = headRec.inum;
  assign tr_pc    = headRec.pc;
  assign tr_reg   = headRec.regIdx;
  assign tr_value = headRec.value;
  assign tr_addr  = headRec.addr;
`ifdef TRACE_CYCLE_STAMP_EN
  assign tr_cycle = headRec.cycle;
`else
  assign tr_cycle = 32'd0;
`endif
  assign done = halted && empty;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed plus randomized bench for commit_trace_buffer with a queue-based reference model.
module tb_commit_trace_buffer;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc;
  logic        reg_write;
  logic [3:0]  write_reg;
  logic [15:0] write_data;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        hlt;
  logic        tr_valid;
  logic        tr_ready;
  logic [2:0]  tr_kind;
  logic [31:0] tr_inum;
  logic [15:0] tr_pc;
  logic [3:0]  tr_reg;
  logic [15:0] tr_value;
  logic [15:0] tr_addr;
  logic [31:0] tr_cycle;
  logic        overflow;
  logic        halted;
  logic        done;

  always #5 clk = ~clk;

  commit_trace_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pc(pc), .reg_write(reg_write), .write_reg(write_reg),
    .write_data(write_data), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_data(mem_data), .hlt(hlt), .tr_valid(tr_valid),
    .tr_ready(tr_ready), .tr_kind(tr_kind), .tr_inum(tr_inum), .tr_pc(tr_pc),
    .tr_reg(tr_reg), .tr_value(tr_value), .tr_addr(tr_addr), .tr_cycle(tr_cycle),
    .overflow(overflow), .halted(halted), .done(done)
  );

  typedef struct {
    logic [2:0]  kind;
    logic [31:0] inum;
    logic [15:0] pc;
    logic [3:0]  rg;
    logic [15:0] value;
    logic [15:0] addr;
    logic [31:0] cyc;
  } rec_t;

  rec_t        expQ[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] mInum;
  logic [31:0] mCyc;
  logic        mOvf;
  logic        mHalt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rw, input logic [3:0] wr, input logic [15:0] wd,
                       input logic mr, input logic mw, input logic [15:0] ma,
                       input logic [15:0] md, input logic h, input logic [15:0] p);
    reg_write = rw; write_reg = wr; write_data = wd; mem_read = mr; mem_write = mw;
    mem_addr = ma; mem_data = md; hlt = h; pc = p;
  endtask

  // Compare current outputs against the model, then advance model and DUT by one edge
  task automatic tick();
    rec_t r;
    rec_t h;
    bit   pop;
    bit   wasFull;
    chk("valid", 32'(tr_valid), 32'(expQ.size() != 0));
    if (expQ.size() != 0) begin
      h = expQ[0];
    end else begin
      h = '{kind: 3'd0, inum: 32'd0, pc: 16'd0, rg: 4'd0, value: 16'd0, addr: 16'd0, cyc: 32'd0};
    end
    chk("kind", 32'(tr_kind), 32'(h.kind));
    chk("inum", tr_inum, h.inum);
    chk("pc", 32'(tr_pc), 32'(h.pc));
    chk("reg", 32'(tr_reg), 32'(h.rg));
    chk("value", 32'(tr_value), 32'(h.value));
    chk("addr", 32'(tr_addr), 32'(h.addr));
`ifdef TRACE_CYCLE_STAMP_EN
    chk("cycle", tr_cycle, h.cyc);
`else
    chk("cycle", tr_cycle, 32'd0);
`endif
    chk("overflow", 32'(overflow), 32'(mOvf));
    chk("halted", 32'(halted), 32'(mHalt));
    chk("done", 32'(done), 32'(mHalt && expQ.size() == 0));

    pop     = (expQ.size() != 0) && tr_ready;
    wasFull = (expQ.size() == DEPTH);
    if (pop) void'(expQ.pop_front());
    if (!mHalt) begin
      r = '{kind: 3'd0, inum: mInum, pc: pc, rg: 4'd0, value: 16'd0, addr: 16'd0, cyc: mCyc};
      if (reg_write) begin
        r.kind  = mem_read ? 3'd2 : 3'd1;
        r.rg    = write_reg;
        r.value = write_data;
        if (mem_read) r.addr = mem_addr;
      end else if (hlt) begin
        r.kind = 3'd4;
      end else if (mem_write) begin
        r.kind  = 3'd3;
        r.value = mem_data;
        r.addr  = mem_addr;
      end
      if (!wasFull || pop) expQ.push_back(r);
      else mOvf = 1'b1;
      mInum = mInum + 32'd1;
      if (r.kind == 3'd4) mHalt = 1'b1;
    end
    mCyc = (mCyc == 32'hFFFF_FFFF) ? mCyc : mCyc + 32'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    expQ.delete();
    mInum = 32'd0;
    mCyc  = 32'd0;
    mOvf  = 1'b0;
    mHalt = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    tr_ready = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    doReset();
    chk("rst_valid", 32'(tr_valid), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_inum", tr_inum, 32'd0);

    // First REG record
    tr_ready = 1'b1;
    drive(1, 4'd3, 16'h00AB, 0, 0, 16'h0, 16'h0, 0, 16'h0000);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 16'h0001);
    chk("first_valid", 32'(tr_valid), 32'd1);
    chk("first_kind", 32'(tr_kind), 32'd1);
    chk("first_inum", tr_inum, 32'd0);
    chk("first_reg", 32'(tr_reg), 32'd3);
    chk("first_value", 32'(tr_value), 32'h00AB);
    tick();
    tick();

    // LOAD then STORE
    doReset();
    tr_ready = 1'b1;
    drive(1, 4'd5, 16'h1234, 1, 0, 16'h0040, 16'h0, 0, 16'h0010);
    tick();
    chk("load_kind", 32'(tr_kind), 32'd2);
    chk("load_addr", 32'(tr_addr), 32'h0040);
    chk("load_value", 32'(tr_value), 32'h1234);
    drive(0, 4'd7, 16'h9999, 0, 1, 16'h0042, 16'h5555, 0, 16'h0011);
    tick();
    chk("store_kind", 32'(tr_kind), 32'd3);
    chk("store_inum", tr_inum, 32'd1);
    chk("store_reg", 32'(tr_reg), 32'd0);
    chk("store_value", 32'(tr_value), 32'h5555);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 16'h0012);
    tick();

    // Overflow: 20 REG captures with consumer stalled, then drain
    doReset();
    tr_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(1, 4'(i), 16'(16'h0100 + i), 0, 0, 0, 0, 0, 16'(i));
      tick();
    end
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_head_inum", tr_inum, 32'd0);
    tr_ready = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 16'h0200);
    for (int i = 0; i < 16; i++) tick();
    chk("ovf_gap_inum", tr_inum, 32'd20);
    tick();

    // Full FIFO with simultaneous pop and push
    doReset();
    tr_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 4'd1, 16'(i), 0, 0, 0, 0, 0, 16'(i));
      tick();
    end
    tr_ready = 1'b1;
    tick();
    chk("fullpop_ovf", 32'(overflow), 32'd0);
    tick();
    tick();

    // HALT behaviour
    doReset();
    tr_ready = 1'b1;
    drive(1, 4'd2, 16'h0BEE, 0, 0, 0, 0, 1, 16'h0030);
    tick();
    chk("hlt_reg_kind", 32'(tr_kind), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 16'h0031);
    tick();
    chk("halt_kind", 32'(tr_kind), 32'd4);
    chk("halt_flag", 32'(halted), 32'd1);
    drive(1, 4'd9, 16'hFFFF, 1, 1, 16'h1111, 16'h2222, 0, 16'h0032);
    tick();
    tick();
    chk("halt_done", 32'(done), 32'd1);
    chk("halt_quiet", 32'(tr_valid), 32'd0);

    // HALT arriving on a full FIFO
    doReset();
    tr_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 0, 0, 0, 1, 16'(i), 16'(i + 3), 0, 16'(i));
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 1, 16'h00FF);
    tick();
    chk("fullhalt_ovf", 32'(overflow), 32'd1);
    chk("fullhalt_halted", 32'(halted), 32'd1);
    tr_ready = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) tick();
    chk("fullhalt_done", 32'(done), 32'd1);

    // Reset with records queued
    doReset();
    tr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1, 4'd4, 16'(i), 0, 0, 0, 0, 0, 16'(i));
      tick();
    end
    doReset();
    chk("midrst_valid", 32'(tr_valid), 32'd0);
    chk("midrst_ovf", 32'(overflow), 32'd0);
    chk("midrst_halted", 32'(halted), 32'd0);
    tr_ready = 1'b1;
    drive(1, 4'd6, 16'h0066, 0, 0, 0, 0, 0, 16'h0050);
    tick();
    chk("midrst_inum", tr_inum, 32'd0);
`ifdef TRACE_CYCLE_STAMP_EN
    chk("midrst_cycle", tr_cycle, 32'd0);
`endif

    // Randomized traffic with random back-pressure
    doReset();
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), 4'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
            1'($urandom_range(0, 63) == 0), 16'($urandom));
      tr_ready = 1'($urandom_range(0, 2) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
